// File: rtl/linear_bias_grad_acc_pkg.sv
// Shared widths, FP32 constants, FSM encoding and a leading-zero helper
// for the linear-layer bias-gradient accumulator.
package linear_bias_grad_acc_pkg;
    localparam int DATA_W = 32;
    localparam int EXP_W  = 8;
    localparam int MAN_W  = 23;
    localparam int ADDR_W = 32;
    localparam logic [DATA_W-1:0] QNAN = 32'h7FC0_0000;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        LOAD,
        ACCUM,
        WRITE,
        DONE
    } bgrad_state_t;

    // Number of leading zeros in a 27-bit extended mantissa (27 when all zero).
    function automatic logic [4:0] lzc27(input logic [26:0] v);
        logic [4:0] n;
        n = 5'd27;
        for (int i = 0; i < 27; i++) begin
            if (v[i]) n = 5'(26 - i);
        end
        return n;
    endfunction
endpackage

// File: rtl/linear_bias_grad_acc_fp32_add.sv
// Combinational IEEE-754 binary32 adder: round-to-nearest-even, denormal inputs
// and results flushed to zero, NaN propagated (quieted), inf - inf = canonical qNaN.
module bgrad_fp32_add
    import linear_bias_grad_acc_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] sum
);
    logic             sa, sb, s_big, s_sml;
    logic [EXP_W-1:0] ea, eb, e_big, e_sml, ediff, shamt;
    logic [MAN_W-1:0] fa, fb, f_big, f_sml;
    logic             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, swap;
    logic [53:0]      sml_wide;
    logic [26:0]      big_x, sml_x, norm;
    logic [27:0]      raw;
    logic [4:0]       lz;
    logic [9:0]       exp_n, exp_r;
    logic [23:0]      frac_r;
    logic             rnd_up;

    assign {sa, ea, fa} = a;
    assign {sb, eb, fb} = b;
    assign a_zero = (ea == '0);
    assign b_zero = (eb == '0);
    assign a_inf  = (ea == '1) && (fa == '0);
    assign b_inf  = (eb == '1) && (fb == '0);
    assign a_nan  = (ea == '1) && (fa != '0);
    assign b_nan  = (eb == '1) && (fb != '0);

    // Magnitude ordering on the raw encoding; only used when both operands are normal.
    assign swap = (b[30:0] > a[30:0]);
    assign {s_big, e_big, f_big} = swap ? b : a;
    assign {s_sml, e_sml, f_sml} = swap ? a : b;

    always_comb begin
        ediff    = e_big - e_sml;
        shamt    = (ediff > 8'd30) ? 8'd30 : ediff;
        sml_wide = {1'b1, f_sml, 30'd0} >> shamt;
        sml_x    = {sml_wide[53:28], sml_wide[27] | (|sml_wide[26:0])};
        big_x    = {1'b1, f_big, 3'b000};
        lz       = '0;
        exp_n    = {2'b00, e_big};
        if (s_big == s_sml) begin
            raw = {1'b0, big_x} + {1'b0, sml_x};
            if (raw[27]) begin
                norm  = {raw[27:2], raw[1] | raw[0]};
                exp_n = exp_n + 10'd1;
            end else begin
                norm = raw[26:0];
            end
        end else begin
            raw   = {1'b0, big_x} - {1'b0, sml_x};
            lz    = lzc27(raw[26:0]);
            norm  = raw[26:0] << lz;
            exp_n = exp_n - {5'd0, lz};
        end
        rnd_up = norm[2] & (norm[3] | norm[1] | norm[0]);
        frac_r = {1'b0, norm[25:3]} + {23'd0, rnd_up};
        exp_r  = exp_n + {9'd0, frac_r[23]};
    end

    // exp_r[9] set means the biased exponent went negative (underflow).
    always_comb begin
        if (a_nan)                           sum = {a[31:23], 1'b1, a[21:0]};
        else if (b_nan)                      sum = {b[31:23], 1'b1, b[21:0]};
        else if (a_inf && b_inf && sa != sb) sum = QNAN;
        else if (a_inf)                      sum = a;
        else if (b_inf)                      sum = b;
        else if (a_zero && b_zero)           sum = {sa & sb, 31'd0};
        else if (a_zero)                     sum = b;
        else if (b_zero)                     sum = a;
        else if (!norm[26])                  sum = '0;
        else if (exp_r[9] || exp_r == '0)    sum = {s_big, 31'd0};
        else if (exp_r >= 10'd255)           sum = {s_big, 8'hFF, 23'd0};
        else                                 sum = {s_big, exp_r[7:0], frac_r[22:0]};
    end
endmodule

// File: rtl/linear_bias_grad_acc.sv
// Bias gradient: d[j] = sum over rows of a[i*n_cols+j], FP32, accumulated in a local bank.
// Latency: 1 element per (read latency + 2) cycles, then one write per column.
// Backpressure: every read/write strobe is held until its done; stalls of any length allowed.
module linear_bias_grad_acc
    import linear_bias_grad_acc_pkg::*;
#(
    parameter int MAX_N = 64,
    parameter int DIM_W = 16
) (
    input  logic              clk,
    input  logic              rst_l,
    output logic [ADDR_W-1:0] a_ptr,
    output logic              a_r_en,
    output logic              a_avail,
    input  logic [DATA_W-1:0] a_data_load,
    input  logic              a_done,
    input  logic [ADDR_W-1:0] a_region_begin,
    output logic [ADDR_W-1:0] d_ptr,
    output logic              d_w_en,
    output logic              d_avail,
    output logic [DATA_W-1:0] d_data_store,
    input  logic              d_done,
    input  logic [ADDR_W-1:0] d_region_begin,
    input  logic [DIM_W-1:0]  n_rows,
    input  logic [DIM_W-1:0]  n_cols,
    input  logic              go,
    output logic              done,
    output logic              err
);
    localparam int COL_W = (MAX_N > 1) ? $clog2(MAX_N) : 1;

    bgrad_state_t      state, state_nx;
    logic [DIM_W-1:0]  rows_q, cols_q, row, col;
    logic [DATA_W-1:0] operand, acc_sel, acc_sum;
    logic [DATA_W-1:0] acc [MAX_N];
    logic              last_col, last_row, dims_zero, dims_big;

    assign acc_sel   = acc[col[COL_W-1:0]];
    assign last_col  = (col == cols_q - DIM_W'(1));
    assign last_row  = (row == rows_q - DIM_W'(1));
    assign dims_zero = (n_rows == '0) || (n_cols == '0);
    assign dims_big  = (n_cols > DIM_W'(MAX_N));

    assign a_avail      = a_r_en;
    assign d_avail      = d_w_en;
    assign d_data_store = d_w_en ? acc_sel : '0;
    assign done         = (state == DONE);

    bgrad_fp32_add u_add (
        .a   (acc_sel),
        .b   (operand),
        .sum (acc_sum)
    );

    always_ff @(posedge clk) begin
        if (!rst_l) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (go) state_nx = (dims_zero || dims_big) ? DONE : CLEAR;
            CLEAR:   state_nx = LOAD;
            LOAD:    if (a_r_en && a_done) state_nx = ACCUM;
            ACCUM:   state_nx = (last_row && last_col) ? WRITE : LOAD;
            WRITE:   if (d_w_en && d_done && last_col) state_nx = DONE;
            DONE:    if (!go) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_l) begin
            a_ptr   <= '0;
            a_r_en  <= 1'b0;
            d_ptr   <= '0;
            d_w_en  <= 1'b0;
            err     <= 1'b0;
            rows_q  <= '0;
            cols_q  <= '0;
            row     <= '0;
            col     <= '0;
            operand <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (go) begin
                        rows_q <= n_rows;
                        cols_q <= n_cols;
                        row    <= '0;
                        col    <= '0;
                        err    <= !dims_zero && dims_big;
                        if (!dims_zero && !dims_big) begin
                            a_ptr <= a_region_begin;
                            d_ptr <= d_region_begin;
                        end
                    end
                end
                CLEAR: a_r_en <= 1'b1;
                LOAD: begin
                    if (a_done) begin
                        a_r_en  <= 1'b0;
                        operand <= a_data_load;
                        a_ptr   <= a_ptr + ADDR_W'(1);
                    end
                end
                ACCUM: begin
                    if (last_col) begin
                        col <= '0;
                        row <= row + DIM_W'(1);
                    end else begin
                        col <= col + DIM_W'(1);
                    end
                    if (last_row && last_col) d_w_en <= 1'b1;
                    else                      a_r_en <= 1'b1;
                end
                WRITE: begin
                    // Strobes drop for one cycle between consecutive writes.
                    if (d_w_en) begin
                        if (d_done) begin
                            d_w_en <= 1'b0;
                            d_ptr  <= d_ptr + ADDR_W'(1);
                            col    <= col + DIM_W'(1);
                        end
                    end else begin
                        d_w_en <= 1'b1;
                    end
                end
                DONE: if (!go) err <= 1'b0;
                default: ;
            endcase
        end
    end

    // Accumulator bank has no reset; it is cleared at the start of every op.
    always_ff @(posedge clk) begin
        if (rst_l && state == CLEAR) begin
            for (int k = 0; k < MAX_N; k++) acc[k] <= '0;
        end else if (rst_l && state == ACCUM) begin
            acc[col[COL_W-1:0]] <= acc_sum;
        end
    end
endmodule

// File: tb/tb_linear_bias_grad_acc.sv
// Self-checking bench for linear_bias_grad_acc: memory responders with configurable
// latency, directed spec cases plus randomized integer-valued matrices.
module tb_linear_bias_grad_acc;
    localparam int TMO = 5000;

    logic        clk = 1'b0;
    logic        rst_l;
    logic [31:0] a_ptr, d_ptr, a_data_load, d_data_store;
    logic        a_r_en, a_avail, a_done, d_w_en, d_avail, d_done;
    logic [15:0] n_rows, n_cols;
    logic        go, done, err;
    logic [31:0] a_base, d_base;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] mem_a [0:1023];
    logic [31:0] mem_d [0:63];
    int          a_count, d_count, lat;
    int          reads = 0, writes = 0, viol = 0, strobe_cycles = 0;

    always #5 clk = ~clk;

    linear_bias_grad_acc #(.MAX_N(64), .DIM_W(16)) dut (
        .clk            (clk),
        .rst_l          (rst_l),
        .a_ptr          (a_ptr),
        .a_r_en         (a_r_en),
        .a_avail        (a_avail),
        .a_data_load    (a_data_load),
        .a_done         (a_done),
        .a_region_begin (a_base),
        .d_ptr          (d_ptr),
        .d_w_en         (d_w_en),
        .d_avail        (d_avail),
        .d_data_store   (d_data_store),
        .d_done         (d_done),
        .d_region_begin (d_base),
        .n_rows         (n_rows),
        .n_cols         (n_cols),
        .go             (go),
        .done           (done),
        .err            (err)
    );

    // Source memory: answers a held read after lat extra cycles; flags protocol breaks.
    initial begin : resp_a
        int cnt;
        cnt = 0;
        a_done = 1'b0;
        a_data_load = '0;
        forever begin
            @(posedge clk); #1;
            if (a_r_en === 1'b1 && !a_done) begin
                if (a_avail !== 1'b1) viol++;
                cnt++;
                if (cnt > lat) begin
                    if (a_ptr < a_base || a_ptr >= a_base + a_count) viol++;
                    else a_data_load = mem_a[10'(a_ptr - a_base)];
                    a_done = 1'b1;
                    reads++;
                    cnt = 0;
                end
            end else begin
                if (a_r_en !== 1'b1 && cnt > 0) viol++;
                a_done = 1'b0;
                cnt = 0;
            end
        end
    end

    initial begin : resp_d
        int cnt;
        cnt = 0;
        d_done = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (d_w_en === 1'b1 && !d_done) begin
                if (d_avail !== 1'b1) viol++;
                cnt++;
                if (cnt > lat) begin
                    if (d_ptr < d_base || d_ptr >= d_base + d_count) viol++;
                    else mem_d[6'(d_ptr - d_base)] = d_data_store;
                    d_done = 1'b1;
                    writes++;
                    cnt = 0;
                end
            end else begin
                d_done = 1'b0;
                cnt = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (a_r_en === 1'b1 || d_w_en === 1'b1 || a_avail === 1'b1 || d_avail === 1'b1)
            strobe_cycles++;
    end

    // Exact FP32 encoding of a small integer (|v| < 2^24).
    function automatic logic [31:0] int2fp(input int v);
        logic [31:0] m;
        int          p;
        if (v == 0) return 32'h0;
        m = (v < 0) ? 32'(-v) : 32'(v);
        p = 0;
        for (int i = 0; i < 32; i++) if (m[i]) p = i;
        m = m << (23 - p);
        return {v < 0, 8'(127 + p), m[22:0]};
    endfunction

    task automatic start_and_wait(input int nr, input int nc, output int cyc);
        n_rows = 16'(nr);
        n_cols = 16'(nc);
        go = 1'b1;
        cyc = 0;
        while (done !== 1'b1 && cyc < TMO) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic drop_go();
        go = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_l = 1'b0;
        go = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({done, err, a_r_en, a_avail, d_w_en, d_avail} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 000000", {done, err, a_r_en, a_avail, d_w_en, d_avail});
        end
        checks++;
        if ({a_ptr, d_ptr, d_data_store} !== 96'h0) begin
            errors++;
            $display("FAIL reset_data: a_ptr %h d_ptr %h store %h expected all 0", a_ptr, d_ptr, d_data_store);
        end
        rst_l = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic(input int latency, input string tag);
        int          cyc, r0, w0, v0;
        logic [31:0] exp_d [2];
        exp_d[0] = 32'h4080_0000;
        exp_d[1] = 32'h40C0_0000;
        mem_a[0] = 32'h3F80_0000; mem_a[1] = 32'h4000_0000;
        mem_a[2] = 32'h4040_0000; mem_a[3] = 32'h4080_0000;
        a_count = 4; d_count = 2; lat = latency;
        r0 = reads; w0 = writes; v0 = viol;
        start_and_wait(2, 2, cyc);
        checks++;
        if (cyc >= TMO || {done, err} !== 2'b10) begin
            errors++;
            $display("FAIL %s_done: done/err %b after %0d cycles expected 10", tag, {done, err}, cyc);
        end
        for (int j = 0; j < 2; j++) begin
            checks++;
            if (mem_d[j] !== exp_d[j]) begin
                errors++;
                $display("FAIL %s_d%0d: got %h expected %h", tag, j, mem_d[j], exp_d[j]);
            end
        end
        checks++;
        if (reads - r0 != 4 || writes - w0 != 2 || viol != v0) begin
            errors++;
            $display("FAIL %s_access: reads %0d writes %0d violations %0d expected 4 2 0",
                     tag, reads - r0, writes - w0, viol - v0);
        end
        drop_go();
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL %s_release: done %b expected 0", tag, done);
        end
    endtask

    task automatic test_single_row();
        int          cyc, w0;
        logic [31:0] exp_d [3];
        exp_d[0] = 32'hBFC0_0000; exp_d[1] = 32'h0000_0000; exp_d[2] = 32'h4100_0000;
        for (int j = 0; j < 3; j++) mem_a[j] = exp_d[j];
        a_count = 3; d_count = 3; lat = 1;
        w0 = writes;
        start_and_wait(1, 3, cyc);
        checks++;
        if (cyc >= TMO || writes - w0 != 3) begin
            errors++;
            $display("FAIL single_row_done: cycles %0d writes %0d expected 3 writes", cyc, writes - w0);
        end
        for (int j = 0; j < 3; j++) begin
            checks++;
            if (mem_d[j] !== exp_d[j]) begin
                errors++;
                $display("FAIL single_row_d%0d: got %h expected %h", j, mem_d[j], exp_d[j]);
            end
        end
        drop_go();
    endtask

    task automatic test_degenerate(input int nr, input int nc, input logic exp_err, input string tag);
        int cyc, s0;
        a_count = 0; d_count = 0; lat = 0;
        s0 = strobe_cycles;
        start_and_wait(nr, nc, cyc);
        checks++;
        if (cyc > 2 || done !== 1'b1 || err !== exp_err) begin
            errors++;
            $display("FAIL %s_done: done %b err %b after %0d cycles expected 1 %b within 2",
                     tag, done, err, cyc, exp_err);
        end
        repeat (3) @(posedge clk);
        #1;
        drop_go();
        checks++;
        if (done !== 1'b0 || strobe_cycles != s0) begin
            errors++;
            $display("FAIL %s_quiet: done %b strobe cycles %0d expected 0 0", tag, done, strobe_cycles - s0);
        end
    endtask

    task automatic test_stall_and_reset();
        int cyc, r0;
        test_basic(10, "stall");
        a_count = 4; d_count = 2; lat = 10;
        r0 = reads;
        n_rows = 16'd2; n_cols = 16'd2; go = 1'b1;
        cyc = 0;
        while (!(reads - r0 == 1 && a_r_en === 1'b1 && !a_done) && cyc < TMO) begin
            @(posedge clk); #1;
            cyc++;
        end
        checks++;
        if (cyc >= TMO) begin
            errors++;
            $display("FAIL reset_mid_wait: second load not reached in %0d cycles", cyc);
        end
        rst_l = 1'b0;
        go = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({a_r_en, a_avail, d_w_en, d_avail, done} !== 5'b0) begin
            errors++;
            $display("FAIL reset_mid_strobes: got %b expected 00000", {a_r_en, a_avail, d_w_en, d_avail, done});
        end
        @(posedge clk); #1;
        rst_l = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        test_basic(0, "rerun");
    endtask

    task automatic test_full_width();
        int cyc;
        for (int i = 0; i < 192; i++) mem_a[i] = 32'h3F80_0000;
        a_count = 192; d_count = 64; lat = 0;
        start_and_wait(3, 64, cyc);
        checks++;
        if (cyc >= TMO || d_ptr !== d_base + 32'd64) begin
            errors++;
            $display("FAIL full_ptr: d_ptr %h expected %h", d_ptr, d_base + 32'd64);
        end
        for (int j = 0; j < 64; j++) begin
            checks++;
            if (mem_d[j] !== 32'h4040_0000) begin
                errors++;
                $display("FAIL full_d%0d: got %h expected 40400000", j, mem_d[j]);
            end
        end
        drop_go();
    endtask

    // Tie/above-tie rounding, inf - inf, and denormal flushing.
    task automatic test_fp_edges();
        int          cyc;
        logic [31:0] exp_d [5];
        mem_a[0] = 32'h3F80_0000; mem_a[1] = 32'h3F80_0000; mem_a[2] = 32'h3F80_0001;
        mem_a[3] = 32'h7F80_0000; mem_a[4] = 32'h0040_0000;
        mem_a[5] = 32'h3380_0000; mem_a[6] = 32'h3380_0001; mem_a[7] = 32'h3380_0000;
        mem_a[8] = 32'hFF80_0000; mem_a[9] = 32'h0040_0000;
        exp_d[0] = 32'h3F80_0000; exp_d[1] = 32'h3F80_0001; exp_d[2] = 32'h3F80_0002;
        exp_d[3] = 32'h7FC0_0000; exp_d[4] = 32'h0000_0000;
        a_count = 10; d_count = 5; lat = 0;
        start_and_wait(2, 5, cyc);
        for (int j = 0; j < 5; j++) begin
            checks++;
            if (cyc >= TMO || mem_d[j] !== exp_d[j]) begin
                errors++;
                $display("FAIL fp_edge_d%0d: got %h expected %h", j, mem_d[j], exp_d[j]);
            end
        end
        drop_go();
    endtask

    task automatic test_random();
        int cyc, nr, nc, r0, w0, v0;
        int sums [16];
        for (int t = 0; t < 8; t++) begin
            nr = int'($urandom_range(1, 6));
            nc = int'($urandom_range(1, 16));
            for (int j = 0; j < 16; j++) sums[j] = 0;
            for (int i = 0; i < nr * nc; i++) begin
                int v;
                v = int'($urandom_range(0, 2000)) - 1000;
                mem_a[i] = int2fp(v);
                sums[i % nc] += v;
            end
            a_base = 32'h1000 + $urandom_range(0, 255);
            d_base = 32'h8000 + $urandom_range(0, 255);
            a_count = nr * nc; d_count = nc;
            lat = int'($urandom_range(0, 3));
            r0 = reads; w0 = writes; v0 = viol;
            start_and_wait(nr, nc, cyc);
            checks++;
            if (cyc >= TMO || reads - r0 != nr * nc || writes - w0 != nc || viol != v0) begin
                errors++;
                $display("FAIL rand%0d_access: reads %0d writes %0d violations %0d expected %0d %0d 0",
                         t, reads - r0, writes - w0, viol - v0, nr * nc, nc);
            end
            for (int j = 0; j < nc; j++) begin
                checks++;
                if (mem_d[j] !== int2fp(sums[j])) begin
                    errors++;
                    $display("FAIL rand%0d_d%0d: got %h expected %h", t, j, mem_d[j], int2fp(sums[j]));
                end
            end
            drop_go();
        end
    endtask

    initial begin
        rst_l = 1'b0;
        go = 1'b0;
        n_rows = '0;
        n_cols = '0;
        a_base = 32'h0000_1000;
        d_base = 32'h0000_8000;
        a_count = 0;
        d_count = 0;
        lat = 0;
        test_reset();
        test_basic(0, "basic");
        test_single_row();
        test_degenerate(0, 4, 1'b0, "zero_rows");
        test_degenerate(3, 65, 1'b1, "too_wide");
        test_stall_and_reset();
        test_full_width();
        test_fp_edges();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
